// File: rtl/cs_pkg.sv
// cs_pkg: shared types and byte-permutation helpers for the CS-Cipher round engine.
package cs_pkg;

  localparam int CS_BLOCK_W = 64;

  typedef logic [CS_BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_WHITEN = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Output byte order, MSB first: source bytes 7,5,3,1,6,4,2,0.
  function automatic block_t perm_bytes(input block_t b);
    return {b[63:56], b[47:40], b[31:24], b[15:8],
            b[55:48], b[39:32], b[23:16], b[7:0]};
  endfunction

  // Undo perm_bytes: put every byte back in its original position.
  function automatic block_t inv_perm_bytes(input block_t y);
    return {y[63:56], y[31:24], y[55:48], y[23:16],
            y[47:40], y[15:8],  y[39:32], y[7:0]};
  endfunction

endpackage

// File: rtl/cs_round_step.sv
// cs_round_step: one cipher round including the round-key XOR.
//   DEC=0: blk_o = P(M(blk_i ^ key_i))
//   DEC=1: blk_o = Minv(Pinv(blk_i)) ^ key_i   (needs CS_ROUND_DEC_EN)
module cs_round_step
  import cs_pkg::*;
#(
  parameter bit DEC = 1'b0
) (
  input  block_t blk_i,
  input  block_t key_i,
  output block_t blk_o
);

  block_t mix_in_s;
  block_t mix_out_s;

`ifdef CS_ROUND_DEC_EN
  if (DEC) begin : g_dec
    assign mix_in_s = inv_perm_bytes(blk_i);
    for (genvar j = 0; j < 4; j++) begin : g_lane
      m_inv_module u_m (.x_i(mix_in_s[16*j +: 16]), .y_o(mix_out_s[16*j +: 16]));
    end
    assign blk_o = mix_out_s ^ key_i;
  end else begin : g_enc
    assign mix_in_s = blk_i ^ key_i;
    for (genvar j = 0; j < 4; j++) begin : g_lane
      m_module u_m (.x_i(mix_in_s[16*j +: 16]), .y_o(mix_out_s[16*j +: 16]));
    end
    assign blk_o = perm_bytes(mix_out_s);
  end
`else
  if (DEC) begin : g_no_dec
    $fatal(1, "cs_round_step: inverse round requires CS_ROUND_DEC_EN");
  end
  assign mix_in_s = blk_i ^ key_i;
  for (genvar j = 0; j < 4; j++) begin : g_lane
    m_module u_m (.x_i(mix_in_s[16*j +: 16]), .y_o(mix_out_s[16*j +: 16]));
  end
  assign blk_o = perm_bytes(mix_out_s);
`endif

endmodule

// File: rtl/m_inv_module.sv
// m_inv_module: inverse of m_module. Only present when CS_ROUND_DEC_EN is defined.
//   yl ^ yr = xl ^ (rotl1(xl) & 8'hAA); that map is an involution, so xl is
//   recovered by applying it again, then xr = yr ^ rotl1(xl).
`ifdef CS_ROUND_DEC_EN
module m_inv_module (
  input  logic [15:0] x_i,
  output logic [15:0] y_o
);

  logic [7:0] d_s;
  logic [7:0] xl_s;
  logic [7:0] rl_s;

  assign d_s  = x_i[15:8] ^ x_i[7:0];
  assign xl_s = d_s ^ ({d_s[6:0], d_s[7]} & 8'hAA);
  assign rl_s = {xl_s[6:0], xl_s[7]};
  assign y_o  = {xl_s, x_i[7:0] ^ rl_s};

endmodule
`endif

// File: rtl/m_module.sv
// m_module: 16-bit CS-Cipher style mixing lane. High byte xl, low byte xr.
//   yl = phi(xl) ^ xr, yr = rotl1(xl) ^ xr, phi(x) = (rotl1(x) & 8'h55) ^ x.
module m_module (
  input  logic [15:0] x_i,
  output logic [15:0] y_o
);

  logic [7:0] xl_s;
  logic [7:0] xr_s;
  logic [7:0] rl_s;
  logic [7:0] phi_s;

  assign xl_s  = x_i[15:8];
  assign xr_s  = x_i[7:0];
  assign rl_s  = {xl_s[6:0], xl_s[7]};
  assign phi_s = (rl_s & 8'h55) ^ xl_s;
  assign y_o   = {phi_s ^ xr_s, rl_s ^ xr_s};

endmodule

// File: rtl/cs_round_engine.sv
// cs_round_engine: iterative CS-Cipher engine, RPC rounds per clock, final whitening XOR.
// Optional macro CS_ROUND_DEC_EN adds a mode_dec port and the inverse (decrypt) datapath.
module cs_round_engine
  import cs_pkg::*;
#(
  parameter int ROUNDS = 8,
  parameter int RPC    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CS_BLOCK_W-1:0]       in_data,
`ifdef CS_ROUND_DEC_EN
  input  logic                        mode_dec,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CS_BLOCK_W-1:0]       out_data,
  output logic [$clog2(ROUNDS+1)-1:0] rk_idx,
  input  logic [CS_BLOCK_W*RPC-1:0]   rk_data
);

  localparam int RKW = $clog2(ROUNDS + 1);
  localparam logic [RKW-1:0] ROUNDS_W    = RKW'(ROUNDS);
  localparam logic [RKW-1:0] RPC_W       = RKW'(RPC);
  localparam logic [RKW-1:0] LAST_DEC_W  = RKW'(RPC - 1);
  localparam logic [RKW-1:0] FIRST_DEC_W = RKW'(ROUNDS - 1);

  if (RPC < 1 || (ROUNDS % RPC) != 0) begin : g_bad_rpc
    $fatal(1, "cs_round_engine: RPC must divide ROUNDS");
  end

  state_e         state_q, state_d;
  logic [RKW-1:0] rnd_q, rnd_d;
  block_t         s_q, s_d;
  block_t         out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           load_s;
  logic           is_dec_s;
  logic           mode_in_s;
  block_t         enc_out_s;
  block_t         dec_out_s;

  // Forward round chain: stage i consumes round key lane i.
  for (genvar i = 0; i < RPC; i++) begin : g_enc
    block_t stage_in_s;
    block_t stage_out_s;
    if (i == 0) begin : g_first
      assign stage_in_s = s_q;
    end else begin : g_next
      assign stage_in_s = g_enc[i-1].stage_out_s;
    end
    cs_round_step #(.DEC(1'b0)) u_step (
      .blk_i(stage_in_s),
      .key_i(rk_data[CS_BLOCK_W*i +: CS_BLOCK_W]),
      .blk_o(stage_out_s)
    );
  end
  assign enc_out_s = g_enc[RPC-1].stage_out_s;

`ifdef CS_ROUND_DEC_EN
  logic dec_q;

  // Inverse round chain: lane i holds rk[rk_idx-i], applied in descending order.
  for (genvar i = 0; i < RPC; i++) begin : g_dec
    block_t stage_in_s;
    block_t stage_out_s;
    if (i == 0) begin : g_first
      assign stage_in_s = s_q;
    end else begin : g_next
      assign stage_in_s = g_dec[i-1].stage_out_s;
    end
    cs_round_step #(.DEC(1'b1)) u_step (
      .blk_i(stage_in_s),
      .key_i(rk_data[CS_BLOCK_W*i +: CS_BLOCK_W]),
      .blk_o(stage_out_s)
    );
  end
  assign dec_out_s = g_dec[RPC-1].stage_out_s;
  assign is_dec_s  = dec_q;
  assign mode_in_s = mode_dec;

  // Direction is captured with the block and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= 1'b0;
    end else if (load_s) begin
      dec_q <= mode_dec;
    end else begin
      dec_q <= dec_q;
    end
  end
`else
  assign dec_out_s = enc_out_s;
  assign is_dec_s  = 1'b0;
  assign mode_in_s = 1'b0;
`endif

  // Next-state, round counter, datapath select and handshake outputs.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    s_d         = s_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    rk_idx      = {RKW{1'b0}};
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        load_s   = in_valid;
      end
      ST_BUSY: begin
        rk_idx = rnd_q;
        if (is_dec_s) begin
          s_d = dec_out_s;
          if (rnd_q == LAST_DEC_W) begin
            state_d     = ST_DONE;
            rnd_d       = {RKW{1'b0}};
            out_d       = dec_out_s;
            out_valid_d = 1'b1;
          end else begin
            rnd_d = rnd_q - RPC_W;
          end
        end else begin
          s_d   = enc_out_s;
          rnd_d = rnd_q + RPC_W;
          if (rnd_q + RPC_W == ROUNDS_W) begin
            state_d = ST_WHITEN;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_WHITEN: begin
        rk_idx = ROUNDS_W;
        s_d    = s_q ^ rk_data[CS_BLOCK_W-1:0];
        if (is_dec_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d     = ST_DONE;
          rnd_d       = {RKW{1'b0}};
          out_d       = s_q ^ rk_data[CS_BLOCK_W-1:0];
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          load_s      = in_valid;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    // A new block overrides whatever the current state planned.
    if (load_s) begin
      s_d     = in_data;
      rnd_d   = mode_in_s ? FIRST_DEC_W : {RKW{1'b0}};
      state_d = mode_in_s ? ST_WHITEN : ST_BUSY;
    end else begin
      s_d = s_d;
    end
  end

  // State, counter, working block and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rnd_q       <= {RKW{1'b0}};
      s_q         <= 64'd0;
      out_q       <= 64'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      s_q         <= s_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule
